// File: rtl/ysyx_22041071_axi_rd_slave.sv
// rtl/ysyx_22041071_axi_rd_slave.sv - AXI4 read responder in front of a 1-cycle-latency word memory
module ysyx_22041071_axi_rd_slave #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                LEN_W     = 8,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h0000_0000_8000_0000,
    parameter logic [ADDR_W-1:0] MEM_BYTES = 64'h0000_0000_0800_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [ID_W-1:0]   ar_id_i,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic [LEN_W-1:0]  ar_len_i,
    input  logic [2:0]        ar_size_i,
    input  logic [1:0]        ar_burst_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [ID_W-1:0]   r_id_o,
    output logic [DATA_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_last_o,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int         OFF_W    = $clog2(DATA_W / 8);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  lat_len;
    logic [LEN_W-1:0]  beat_cnt;
    logic [2:0]        lat_size;
    logic [1:0]        lat_burst;

    logic              ar_hs;
    logic              r_hs;
    logic [ADDR_W-1:0] fetch_addr;
    logic [1:0]        fetch_resp;
    logic [1:0]        cur_resp;

    // Burst type and size errors dominate; otherwise the beat address decides decode.
    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] addr,
                                             input logic [1:0]        burst,
                                             input logic [2:0]        size);
        if (burst[1] || (size > MAX_SIZE))
            return RESP_SLVERR;
        if ((addr < MEM_BASE) || ((addr - MEM_BASE) >= MEM_BYTES))
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    // Next INCR beat: align to the transfer size, then step one transfer; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] incr_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        size);
        logic [ADDR_W-1:0] step;
        step = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
        return (addr & ~(step - 1'b1)) + step;
    endfunction

    assign ar_hs = (state == S_IDLE) && ar_valid_i && ar_ready_o;
    assign r_hs  = (state == S_RESP) && r_valid_o && r_ready_i;

    // Address and response of the beat about to be fetched (first beat or the following one).
    always_comb begin
        fetch_addr = cur_addr;
        fetch_resp = RESP_OKAY;
        if (ar_hs) begin
            fetch_addr = ar_addr_i;
            fetch_resp = beat_resp(ar_addr_i, ar_burst_i, ar_size_i);
        end else begin
            if (lat_burst != BURST_FIXED)
                fetch_addr = incr_addr(cur_addr, lat_size);
            fetch_resp = beat_resp(fetch_addr, lat_burst, lat_size);
        end
    end

    assign cur_resp = beat_resp(cur_addr, lat_burst, lat_size);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: fixed FETCH/LOAD cadence, RESP waits for the R handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ar_hs) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RESP;
            S_RESP:  if (r_hs) state_nxt = r_last_o ? S_IDLE : S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered AR/R/memory outputs and burst bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_data_o   <= '0;
            r_resp_o   <= RESP_OKAY;
            r_id_o     <= '0;
            mem_ren_o  <= 1'b0;
            mem_addr_o <= '0;
            cur_addr   <= '0;
            lat_len    <= '0;
            beat_cnt   <= '0;
            lat_size   <= '0;
            lat_burst  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ar_hs) begin
                        ar_ready_o <= 1'b0;
                        r_id_o     <= ar_id_i;
                        cur_addr   <= ar_addr_i;
                        lat_len    <= ar_len_i;
                        lat_size   <= ar_size_i;
                        lat_burst  <= ar_burst_i;
                        beat_cnt   <= '0;
                        mem_ren_o  <= (fetch_resp == RESP_OKAY);
                        mem_addr_o <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        ar_ready_o <= 1'b1;
                    end
                end
                S_FETCH: begin
                    mem_ren_o <= 1'b0;
                end
                S_LOAD: begin
                    r_valid_o <= 1'b1;
                    r_resp_o  <= cur_resp;
                    r_data_o  <= (cur_resp == RESP_OKAY) ? mem_rdata_i : '0;
                    r_last_o  <= (beat_cnt == lat_len);
                end
                S_RESP: begin
                    if (r_hs) begin
                        r_valid_o <= 1'b0;
                        r_last_o  <= 1'b0;
                        if (r_last_o) begin
                            ar_ready_o <= 1'b1;
                        end else begin
                            cur_addr   <= fetch_addr;
                            beat_cnt   <= beat_cnt + 1'b1;
                            mem_ren_o  <= (fetch_resp == RESP_OKAY);
                            mem_addr_o <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
